// File: rtl/gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3.sv
// Round-robin grant sequencer for a shared 3-input AOI222 read mux; registered grant, 1-edge grant latency from IDLE.
// No backpressure: requests are levels and are never latched, so a requester simply holds REQ until it is served.
module gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3 #(
    parameter int W       = 8,
    parameter int MAXHOLD = 16,
    parameter int GAP     = 1
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic [2:0]   REQ,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic [W-1:0] D2,
    output logic [2:0]   GNT,
    output logic [W-1:0] ZN,
    output logic         VALID,
    output logic         PREEMPT,
    output logic [1:0]   PTR
);

    localparam int HCW = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1);
    localparam logic [HCW-1:0] HC_SAT  = (MAXHOLD == 0) ? '1 : HCW'(MAXHOLD);
    localparam logic [2:0]     GC_INIT = 3'(GAP);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    logic [1:0]     state;
    logic [HCW-1:0] hc;
    logic [2:0]     gc;

    logic [1:0] ord0, ord1, ord2;
    logic [1:0] win;
    logic       win_vld;
    logic       owner_req;
    logic       timeout;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Search order starts just after the last winner, so the last owner is always lowest priority.
    always_comb begin
        ord0 = 2'd0;
        ord1 = 2'd1;
        ord2 = 2'd2;
        case (PTR)
            2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
            2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
            default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
        endcase
        win_vld = |REQ;
        win     = ord2;
        if (REQ[ord1]) win = ord1;
        if (REQ[ord0]) win = ord0;
    end

    // While a grant is held PTR names the owner.
    assign owner_req = REQ[PTR];
    assign timeout   = (MAXHOLD != 0) && (hc == HC_SAT);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state   <= ST_IDLE;
            GNT     <= 3'b000;
            VALID   <= 1'b0;
            PREEMPT <= 1'b0;
            PTR     <= 2'd2;
            hc      <= '0;
            gc      <= 3'd0;
        end else begin
            PREEMPT <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        GNT   <= onehot(win);
                        VALID <= 1'b1;
                        PTR   <= win;
                        hc    <= HCW'(1);
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    // A release on the timeout edge counts as a release, hence PREEMPT follows owner_req.
                    if (!owner_req || timeout) begin
                        GNT     <= 3'b000;
                        VALID   <= 1'b0;
                        PREEMPT <= owner_req;
                        hc      <= '0;
                        gc      <= GC_INIT;
                        state   <= ST_DEAD;
                    end else if (hc != HC_SAT) begin
                        hc <= hc + HCW'(1);
                    end
                end
                ST_DEAD: begin
                    if (gc <= 3'd1) begin
                        gc <= 3'd0;
                        if (win_vld) begin
                            GNT   <= onehot(win);
                            VALID <= 1'b1;
                            PTR   <= win;
                            hc    <= HCW'(1);
                            state <= ST_OWN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gc <= gc - 3'd1;
                    end
                end
                default: begin
                    GNT   <= 3'b000;
                    VALID <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ZN = ~(({W{GNT[0]}} & D0) | ({W{GNT[1]}} & D1) | ({W{GNT[2]}} & D2));
    end

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RN) $onehot0(GNT));

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3.sv
// Scoreboarded directed bench: three arbiter instances with different hold/gap settings.
module tb_gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rn;
    logic [2:0][2:0] req;
    logic [2:0][7:0] dat0, dat1, dat2;
    logic [2:0][2:0] gnt;
    logic [2:0][7:0] zn;
    logic [2:0]      valid;
    logic [2:0]      preempt;
    logic [2:0][1:0] ptr;

    // Instance 0: defaults. Instance 1: MAXHOLD=4, GAP=2. Instance 2: MAXHOLD=3, GAP=1.
    gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3 #(.W(8), .MAXHOLD(16), .GAP(1)) u_a (
        .CLK(clk), .RN(rn[0]), .REQ(req[0]), .D0(dat0[0]), .D1(dat1[0]), .D2(dat2[0]),
        .GNT(gnt[0]), .ZN(zn[0]), .VALID(valid[0]), .PREEMPT(preempt[0]), .PTR(ptr[0]));
    gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3 #(.W(8), .MAXHOLD(4), .GAP(2)) u_b (
        .CLK(clk), .RN(rn[1]), .REQ(req[1]), .D0(dat0[1]), .D1(dat1[1]), .D2(dat2[1]),
        .GNT(gnt[1]), .ZN(zn[1]), .VALID(valid[1]), .PREEMPT(preempt[1]), .PTR(ptr[1]));
    gf180mcu_fd_sc_mcu7t5v0_aoi222_arb3 #(.W(8), .MAXHOLD(3), .GAP(1)) u_c (
        .CLK(clk), .RN(rn[2]), .REQ(req[2]), .D0(dat0[2]), .D1(dat1[2]), .D2(dat2[2]),
        .GNT(gnt[2]), .ZN(zn[2]), .VALID(valid[2]), .PREEMPT(preempt[2]), .PTR(ptr[2]));

    typedef struct {
        int         inst;
        logic [2:0] gnt;
        logic       pre;
        logic [1:0] ptr;
        logic [7:0] zn;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step(input int i, input logic r, input logic [2:0] q,
                        input logic [2:0] eg, input logic ep, input logic [1:0] et,
                        input logic [7:0] ez, input string nm);
        exp_t e;
        @(negedge clk);
        rn[i]  = r;
        req[i] = q;
        @(posedge clk);
        #1;
        e.inst = i; e.gnt = eg; e.pre = ep; e.ptr = et; e.zn = ez; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with a pending expectation is checked against the outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (gnt[e.inst] !== e.gnt) begin
                    n_err++;
                    $display("FAIL %s gnt[%0d]: got %b want %b", e.name, e.inst, gnt[e.inst], e.gnt);
                end
                if (preempt[e.inst] !== e.pre) begin
                    n_err++;
                    $display("FAIL %s preempt[%0d]: got %b want %b", e.name, e.inst, preempt[e.inst], e.pre);
                end
                if (ptr[e.inst] !== e.ptr) begin
                    n_err++;
                    $display("FAIL %s ptr[%0d]: got %0d want %0d", e.name, e.inst, ptr[e.inst], e.ptr);
                end
                if (zn[e.inst] !== e.zn) begin
                    n_err++;
                    $display("FAIL %s zn[%0d]: got %h want %h", e.name, e.inst, zn[e.inst], e.zn);
                end
                if (valid[e.inst] !== (e.gnt != 3'b000)) begin
                    n_err++;
                    $display("FAIL %s valid[%0d]: got %b want %b", e.name, e.inst, valid[e.inst], (e.gnt != 3'b000));
                end
            end
        end
    end

    initial begin
        rn   = 3'b000;
        req  = '0;
        dat0 = {8'h12, 8'h0F, 8'h00};
        dat1 = {8'h34, 8'h3C, 8'hA5};
        dat2 = {8'h56, 8'hC3, 8'hFF};

        // Instance 0: reset with all requests, then round-robin with 3-cycle holds.
        step(0, 1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 8'hFF, "rst0");
        step(0, 1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 8'hFF, "rst1");
        step(0, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 8'hFF, "rr_g0a");
        step(0, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 8'hFF, "rr_g0b");
        step(0, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 8'hFF, "rr_g0c");
        step(0, 1'b1, 3'b110, 3'b000, 1'b0, 2'd0, 8'hFF, "rr_dead0");
        step(0, 1'b1, 3'b111, 3'b010, 1'b0, 2'd1, 8'h5A, "rr_g1a");
        step(0, 1'b1, 3'b111, 3'b010, 1'b0, 2'd1, 8'h5A, "rr_g1b");
        step(0, 1'b1, 3'b111, 3'b010, 1'b0, 2'd1, 8'h5A, "rr_g1c");
        step(0, 1'b1, 3'b101, 3'b000, 1'b0, 2'd1, 8'hFF, "rr_dead1");
        step(0, 1'b1, 3'b111, 3'b100, 1'b0, 2'd2, 8'h00, "rr_g2a");
        step(0, 1'b1, 3'b111, 3'b100, 1'b0, 2'd2, 8'h00, "rr_g2b");
        step(0, 1'b1, 3'b111, 3'b100, 1'b0, 2'd2, 8'h00, "rr_g2c");
        step(0, 1'b1, 3'b011, 3'b000, 1'b0, 2'd2, 8'hFF, "rr_dead2");
        step(0, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 8'hFF, "rr_wrap");
        // Walk to a grant of agent 2, then reset in the middle of it.
        step(0, 1'b1, 3'b110, 3'b000, 1'b0, 2'd0, 8'hFF, "mg_rel0");
        step(0, 1'b1, 3'b111, 3'b010, 1'b0, 2'd1, 8'h5A, "mg_g1");
        step(0, 1'b1, 3'b101, 3'b000, 1'b0, 2'd1, 8'hFF, "mg_rel1");
        step(0, 1'b1, 3'b111, 3'b100, 1'b0, 2'd2, 8'h00, "mg_g2");
        step(0, 1'b0, 3'b111, 3'b000, 1'b0, 2'd2, 8'hFF, "mg_rst");
        step(0, 1'b1, 3'b111, 3'b001, 1'b0, 2'd0, 8'hFF, "mg_nogap");
        step(0, 1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 8'hFF, "mg_park");

        // Instance 1: timeout with a single requester, then with two.
        step(1, 1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 8'hFF, "to_rst");
        step(1, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 8'hF0, "to_h1");
        step(1, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 8'hF0, "to_h2");
        step(1, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 8'hF0, "to_h3");
        step(1, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 8'hF0, "to_h4");
        step(1, 1'b1, 3'b001, 3'b000, 1'b1, 2'd0, 8'hFF, "to_pre");
        step(1, 1'b1, 3'b001, 3'b000, 1'b0, 2'd0, 8'hFF, "to_gap2");
        step(1, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 8'hF0, "to_regrant");
        step(1, 1'b1, 3'b011, 3'b001, 1'b0, 2'd0, 8'hF0, "to2_h2");
        step(1, 1'b1, 3'b011, 3'b001, 1'b0, 2'd0, 8'hF0, "to2_h3");
        step(1, 1'b1, 3'b011, 3'b001, 1'b0, 2'd0, 8'hF0, "to2_h4");
        step(1, 1'b1, 3'b011, 3'b000, 1'b1, 2'd0, 8'hFF, "to2_pre");
        step(1, 1'b1, 3'b011, 3'b000, 1'b0, 2'd0, 8'hFF, "to2_gap2");
        step(1, 1'b1, 3'b011, 3'b010, 1'b0, 2'd1, 8'hC3, "to2_next");
        step(1, 1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 8'hFF, "to2_rel");
        step(1, 1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 8'hFF, "to2_gap");
        step(1, 1'b1, 3'b000, 3'b000, 1'b0, 2'd1, 8'hFF, "to2_idle");

        // Instance 2: release coinciding with timeout, then a plain timeout with GAP=1.
        step(2, 1'b0, 3'b000, 3'b000, 1'b0, 2'd2, 8'hFF, "rt_rst");
        step(2, 1'b1, 3'b100, 3'b100, 1'b0, 2'd2, 8'hA9, "rt_h1");
        step(2, 1'b1, 3'b100, 3'b100, 1'b0, 2'd2, 8'hA9, "rt_h2");
        step(2, 1'b1, 3'b100, 3'b100, 1'b0, 2'd2, 8'hA9, "rt_h3");
        step(2, 1'b1, 3'b000, 3'b000, 1'b0, 2'd2, 8'hFF, "rt_relto");
        step(2, 1'b1, 3'b000, 3'b000, 1'b0, 2'd2, 8'hFF, "rt_idle");
        step(2, 1'b1, 3'b010, 3'b010, 1'b0, 2'd1, 8'hCB, "pt_h1");
        step(2, 1'b1, 3'b010, 3'b010, 1'b0, 2'd1, 8'hCB, "pt_h2");
        step(2, 1'b1, 3'b010, 3'b010, 1'b0, 2'd1, 8'hCB, "pt_h3");
        step(2, 1'b1, 3'b010, 3'b000, 1'b1, 2'd1, 8'hFF, "pt_pre");
        step(2, 1'b1, 3'b010, 3'b010, 1'b0, 2'd1, 8'hCB, "pt_regrant");

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
